// File: rtl/stream_mux_n_if.sv
// Handshake bundle between the channel sources, stream_mux_n and its downstream sink.
// master drives the channel words and out_ready; slave is the mux itself.
interface stream_mux_n_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int SELW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SELW-1:0]           sel;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/stream_mux_n.sv
// N-channel valid/ready mux into one registered output; explicit select (MODE 0) or round-robin (MODE 1).
// Latency 1 cycle; a channel is accepted only when the output register is empty or draining this cycle.
module stream_mux_n #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0
) (
  input logic           clk,
  input logic           rst_n,
  stream_mux_n_if.slave s
);
  localparam int SELW = $clog2(CHANNELS);
  localparam logic [SELW-1:0] PTR_RST = SELW'(CHANNELS - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             load_en, gnt_vld, xfer;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_dat;
  int               cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_dat = '0;
    cand    = 0;
    if (MODE == 0) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (int'(s.sel) == k && s.in_valid[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(k);
          gnt_dat = s.in_data[k*WIDTH +: WIDTH];
        end
      end
    end else begin
      // Search starts just after the last served channel so each requester waits at most N-1 grants.
      for (int i = 1; i <= CHANNELS; i++) begin
        cand = (int'(ptr_q) + i) % CHANNELS;
        for (int k = 0; k < CHANNELS; k++) begin
          if (!gnt_vld && cand == k && s.in_valid[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(k);
            gnt_dat = s.in_data[k*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign load_en    = !out_valid_q || s.out_ready;
  assign xfer       = load_en && gnt_vld;
  assign s.in_ready = (rst_n && xfer) ? (CHANNELS'(1) << gnt_idx) : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = gnt_vld;
    end
    if (xfer) begin
      out_data_d = gnt_dat;
      out_chan_d = gnt_idx;
      ptr_d      = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= PTR_RST;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign s.out_data  = out_data_q;
  assign s.out_chan  = out_chan_q;
  assign s.out_valid = out_valid_q;
endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: one instance per MODE, each with its own reference model and scoreboard.
module tb_stream_mux_n;
  localparam int W   = 32;
  localparam int NCH = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   c;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic fin   = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [NCH*W-1:0] id [2];
  logic [NCH-1:0]   iv [2];
  logic [1:0]       sl [2];
  logic [1:0]       ordy;
  logic [NCH-1:0]   ir [2];
  logic [W-1:0]     od [2];
  logic [1:0]       oc [2];
  logic [1:0]       ov;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Grant chosen purely from the rules: fixed select, or first requester after the last winner.
  function automatic int ref_grant(input int mode, input int ptr, input logic [NCH-1:0] v, input int sel);
    int c;
    if (mode == 0) return v[sel[1:0]] ? sel : -1;
    for (int i = 1; i <= NCH; i++) begin
      c = (ptr + i) % NCH;
      if (v[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar m = 0; m < 2; m++) begin : g
    stream_mux_n_if #(.WIDTH(W), .CHANNELS(NCH)) bus ();
    stream_mux_n #(.WIDTH(W), .CHANNELS(NCH), .MODE(m)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .s    (bus)
    );
    assign bus.in_data   = id[m];
    assign bus.in_valid  = iv[m];
    assign bus.sel       = sl[m];
    assign bus.out_ready = ordy[m];
    assign ir[m]         = bus.in_ready;
    assign od[m]         = bus.out_data;
    assign oc[m]         = bus.out_chan;
    assign ov[m]         = bus.out_valid;

    exp_t sq[$];
    logic full;
    int   ptr;

    initial begin : model
      int   gv;
      logic load;
      full = 1'b0;
      ptr  = NCH - 1;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          full = 1'b0;
          ptr  = NCH - 1;
          sq.delete();
          check($sformatf("m%0d_rst_in_ready", m), 64'(ir[m]), 64'(0));
        end else begin
          gv   = ref_grant(m, ptr, iv[m], int'(sl[m]));
          load = !full || ordy[m];
          check($sformatf("m%0d_in_ready", m), 64'(ir[m]),
                (load && gv >= 0) ? 64'(1 << gv) : 64'(0));
          @(posedge clk);
          if (rst_n && load) begin
            full = (gv >= 0);
            if (gv >= 0) begin
              sq.push_back('{d: id[m][gv*W +: W], c: 2'(gv)});
              ptr = gv;
            end
          end
        end
      end
    end

    initial begin : monitor
      exp_t         e;
      logic         hold;
      logic [W-1:0] hd;
      logic [1:0]   hc;
      hold = 1'b0;
      hd   = '0;
      hc   = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          hold = 1'b0;
        end else begin
          if (hold) begin
            check($sformatf("m%0d_hold_data", m), 64'(od[m]), 64'(hd));
            check($sformatf("m%0d_hold_chan", m), 64'(oc[m]), 64'(hc));
          end
          check($sformatf("m%0d_out_valid", m), 64'(ov[m]), 64'(full));
          if (ov[m] && ordy[m]) begin
            check($sformatf("m%0d_word_expected", m), 64'(sq.size() != 0), 64'(1));
            if (sq.size() != 0) begin
              e = sq.pop_front();
              check($sformatf("m%0d_out_data", m), 64'(od[m]), 64'(e.d));
              check($sformatf("m%0d_out_chan", m), 64'(oc[m]), 64'(e.c));
            end
          end
          hold = ov[m] && !ordy[m];
          hd   = od[m];
          hc   = oc[m];
        end
      end
    end

    initial begin : drain_check
      wait (fin);
      @(negedge clk);
      check($sformatf("m%0d_drain_empty", m), 64'(sq.size()), 64'(0));
      check($sformatf("m%0d_drain_valid", m), 64'(ov[m]), 64'(0));
    end
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      id[m] = '0;
      iv[m] = '0;
      sl[m] = '0;
    end
    ordy = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check("rst_out_valid", 64'(ov[m]), 64'(0));
      check("rst_out_data", 64'(od[m]), 64'(0));
      check("rst_out_chan", 64'(oc[m]), 64'(0));
      check("rst_in_ready", 64'(ir[m]), 64'(0));
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Explicit select, requested channel valid
    sl[0] = 2'd2;
    iv[0] = 4'b0100;
    id[0][2*W +: W] = 32'hDEADBEEF;
    ordy[0] = 1'b1;
    #1 check("sel2_in_ready", 64'(ir[0]), 64'(4'b0100));
    tick();
    check("sel2_data", 64'(od[0]), 64'(32'hDEADBEEF));
    check("sel2_chan", 64'(oc[0]), 64'(2));
    check("sel2_valid", 64'(ov[0]), 64'(1));

    // Explicit select, requested channel idle
    iv[0] = 4'b0001;
    #1 check("sel_idle_in_ready", 64'(ir[0]), 64'(0));
    tick();
    check("sel_idle_valid", 64'(ov[0]), 64'(0));

    // Backpressure: three stalled cycles, then back-to-back words
    iv[0] = 4'b1111;
    sl[0] = 2'd1;
    ordy[0] = 1'b0;
    id[0][1*W +: W] = 32'h11110001;
    tick();
    check("bp_first_data", 64'(od[0]), 64'(32'h11110001));
    id[0][1*W +: W] = 32'h22220002;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_stall_in_ready", 64'(ir[0]), 64'(0));
      tick();
      check("bp_stall_data", 64'(od[0]), 64'(32'h11110001));
      check("bp_stall_chan", 64'(oc[0]), 64'(1));
      check("bp_stall_valid", 64'(ov[0]), 64'(1));
    end
    ordy[0] = 1'b1;
    #1 check("bp_release_in_ready", 64'(ir[0]), 64'(4'b0010));
    tick();
    check("bp_next_data", 64'(od[0]), 64'(32'h22220002));
    id[0][1*W +: W] = 32'h33330003;
    tick();
    check("bp_nogap_data", 64'(od[0]), 64'(32'h33330003));
    check("bp_nogap_valid", 64'(ov[0]), 64'(1));
    iv[0] = '0;

    // Round-robin with all channels requesting, sel ignored
    iv[1] = 4'b1111;
    ordy[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      id[1] = {$urandom, $urandom, $urandom, $urandom};
      sl[1] = 2'($urandom);
      tick();
      check("rr_all_chan", 64'(oc[1]), 64'(k % 4));
      check("rr_all_valid", 64'(ov[1]), 64'(1));
    end

    // Reset in the middle of a cycle while a word is held
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid0", 64'(ov[0]), 64'(0));
    check("midrst_valid1", 64'(ov[1]), 64'(0));
    check("midrst_data1", 64'(od[1]), 64'(0));
    check("midrst_chan1", 64'(oc[1]), 64'(0));
    check("midrst_in_ready1", 64'(ir[1]), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("postrst_first_chan", 64'(oc[1]), 64'(0));
    check("postrst_first_valid", 64'(ov[1]), 64'(1));

    // Round-robin over channels 1 and 3 only
    iv[1] = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_1010_chan", 64'(oc[1]), (k % 2 == 0) ? 64'(1) : 64'(3));
    end

    // Random traffic on both instances, with one reset in the middle
    for (int n = 0; n < 600; n++) begin
      for (int m = 0; m < 2; m++) begin
        iv[m]   = 4'($urandom);
        sl[m]   = 2'($urandom);
        id[m]   = {$urandom, $urandom, $urandom, $urandom};
        ordy[m] = ($urandom_range(0, 3) != 0);
      end
      if (n == 300) rst_n = 1'b0;
      if (n == 303) rst_n = 1'b1;
      tick();
    end

    for (int m = 0; m < 2; m++) iv[m] = '0;
    ordy = 2'b11;
    repeat (3) tick();
    fin = 1'b1;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stream_mux_n.md
STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 The block SHALL have parameter CHANNELS, default 4, number of input channels (>=2).
REQ-003 The block SHALL have parameter MODE, default 0; 0 = explicit select, 1 = round-robin arbitration.
REQ-004 The block SHALL have derived localparam SELW = clog2(CHANNELS), channel index width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_valid  input  CHANNELS  per-channel word-available flag.
REQ-010 in_ready  output  CHANNELS  per-channel accept flag, combinational.
REQ-011 sel  input  SELW  channel select; used in MODE 0 only.
REQ-012 out_data  output  WIDTH  registered output word.
REQ-013 out_chan  output  SELW  registered index of the channel that supplied out_data.
REQ-014 out_valid  output  1  registered output-word-valid flag.
REQ-015 out_ready  input  1  downstream accept flag.

Function
REQ-016 load_en SHALL be defined as (!out_valid | out_ready); the output register accepts a new word only when load_en=1.
REQ-017 MODE 0: grant SHALL go to channel sel when sel<CHANNELS and in_valid[sel]=1; otherwise there is no grant.
REQ-018 MODE 1: grant SHALL go to the first channel with in_valid=1, searching ptr+1, ptr+2, ... modulo CHANNELS; sel SHALL be ignored.
REQ-019 Round-robin pointer ptr SHALL update to the granted index only on a completed input transfer, and hold otherwise.
REQ-020 in_ready[g] SHALL be 1 only for granted channel g, and only when load_en=1; all other bits SHALL be 0.
REQ-021 An input transfer SHALL occur on a rising edge with in_valid[g]=1 and in_ready[g]=1.
REQ-022 On an input transfer: out_data<=in_data[g], out_chan<=g, out_valid<=1.
REQ-023 If load_en=1 and there is no grant, out_valid SHALL go to 0; out_data and out_chan SHALL hold.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold stable.
REQ-025 Latency SHALL be 1 cycle from input transfer to out_valid=1; sustained throughput SHALL be 1 word per cycle with out_ready held at 1.
REQ-026 A simultaneous output drain and input transfer in the same cycle SHALL replace the word with no bubble.
REQ-027 No word SHALL be duplicated or lost; each accepted word SHALL appear on the output exactly once.

Reset
REQ-028 rst_n=0 SHALL immediately force out_valid=0, out_data=0, out_chan=0, ptr=CHANNELS-1, independent of clk.
REQ-029 in_ready SHALL be all 0 while rst_n=0.
REQ-030 Reset mid-operation SHALL discard any held output word.
REQ-031 After release, MODE 1 arbitration SHALL start search from channel 0.

Verification (WIDTH=32, CHANNELS=4)
REQ-032 MODE 0 scenario: sel=2, in_valid=4'b0100, ch2 data 32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hDEADBEEF, out_chan=2.
REQ-033 MODE 0 scenario: sel=2, in_valid=4'b0001 -> in_ready=4'b0000; out_valid=0 next cycle.
REQ-034 Backpressure scenario: out_valid=1, out_ready=0 for 3 cycles, all inputs valid -> in_ready=4'b0000 and outputs unchanged; then out_ready=1 -> new word next cycle with no gap thereafter.
REQ-035 MODE 1 scenario: in_valid=4'b1111 constant, out_ready=1, from reset -> out_chan sequence 0,1,2,3,0,1.
REQ-036 MODE 1 scenario: in_valid=4'b1010 -> out_chan sequence 1,3,1,3; no grant to channel 0 or 2.
REQ-037 Reset scenario: rst_n driven low mid-cycle with out_valid=1 -> out_valid=0 before the next clock edge; after release with in_valid=4'b1111, first out_chan=0.
